uart_tx_sched_bins: RTL and testbench

//  Shares one uart_tx transmitter between NUM_CH byte-stream requesters, with frame-granular round-robin arbitration.

---
 rtl/uart_bins_pkg.sv | 25 ++
 rtl/rr_arbiter_bins.sv | 31 +++
 rtl/uart_tx_sched_bins.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_sched_bins.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bins_pkg.sv
// Shared types and constants for the BINS UART frame scheduler.
package uart_bins_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned ID_W          = 3;

  typedef enum logic [3:0] {
    StIdle,
    StHdrSync,
    StHdrId,
    StFetch,
    StLoad,
    StWaitBusy,
    StWaitDone,
    StDrain,
    StGap
  } state_e;

  typedef enum logic [1:0] {
    Sync,
    Id,
    Payload
  } byte_kind_t;

endpackage

// File: rtl/rr_arbiter_bins.sv
// Round-robin arbiter: first request at or after ptr, searching upward with wrap.
module rr_arbiter_bins #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PtrW   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PtrW-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [PtrW-1:0]   ptr_next
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    cand     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (32'(ptr) + i) % NUM_CH;
      if (en && !found && req[cand[PtrW-1:0]]) begin
        gnt[cand[PtrW-1:0]] = 1'b1;
        ptr_next            = PtrW'((cand + 1) % NUM_CH);
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched_bins.sv
// Frame-granular round-robin scheduler sharing one uart_tx among NUM_CH byte streams.
module uart_tx_sched_bins
  import uart_bins_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned MAX_FRAME   = 64,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned GAP_CLKS    = 16
) (
  input  logic                clockIN,
  input  logic                nResetIN,
  input  logic [NUM_CH-1:0]   chValidIN,
  input  logic [8*NUM_CH-1:0] chDataIN,
  input  logic [NUM_CH-1:0]   chLastIN,
  output logic [NUM_CH-1:0]   chReadyOUT,
  input  logic                txReadyIN,
  output logic [7:0]          txDataOUT,
  output logic                txLoadOUT,
  output logic [NUM_CH-1:0]   grantOUT,
  output logic                busyOUT,
  output logic                errAckOUT,
  output logic                errLenOUT
);

  localparam int unsigned PtrW = $clog2(NUM_CH);
  localparam int unsigned CntW = $clog2(MAX_FRAME + 1);
  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(GAP_CLKS + 1);

  state_e            state_q;
  byte_kind_t        kind_q;
  logic [PtrW-1:0]   ptr_q, idx_q;
  logic [CntW-1:0]   cnt_q;
  logic [AckW-1:0]   ack_q;
  logic [GapW-1:0]   gap_q;
  logic              last_q;
  logic              rdy_meta_q, rdy_sync_q;
  logic [NUM_CH-1:0] rdy_q, gnt_q;
  logic [7:0]        data_q;
  logic              load_q, err_ack_q, err_len_q;

  logic [NUM_CH-1:0] arb_gnt;
  logic [PtrW-1:0]   arb_ptr_nxt, arb_idx;
  logic [7:0]        ch_byte;
  logic              ch_valid, ch_last, take;
  logic              ack_expired, byte_done;
  state_e            route_st;

  rr_arbiter_bins #(
    .NUM_CH (NUM_CH),
    .PtrW   (PtrW)
  ) u_arb (
    .req      (chValidIN),
    .ptr      (ptr_q),
    .en       (state_q == StIdle),
    .gnt      (arb_gnt),
    .ptr_next (arb_ptr_nxt)
  );

  // The granted index is the one just before the advanced pointer.
  assign arb_idx  = (arb_ptr_nxt == '0) ? PtrW'(NUM_CH - 1) : arb_ptr_nxt - PtrW'(1);

  assign ch_byte  = chDataIN[{idx_q, 3'b000} +: 8];
  assign ch_valid = chValidIN[idx_q];
  assign ch_last  = chLastIN[idx_q];
  assign take     = ch_valid & rdy_q[idx_q];

  assign ack_expired = (ack_q == AckW'(ACK_TIMEOUT - 1));
  // A timed-out wait for busy is treated exactly like a completed byte.
  assign byte_done   = ((state_q == StWaitDone) && rdy_sync_q) ||
                       ((state_q == StWaitBusy) && rdy_sync_q && ack_expired);

  always_comb begin
    route_st = StFetch;
    case (kind_q)
      Sync:    route_st = StHdrId;
      Id:      route_st = StFetch;
      default: begin
        if (last_q)                           route_st = StGap;
        else if (cnt_q == CntW'(MAX_FRAME))   route_st = StDrain;
        else                                  route_st = StFetch;
      end
    endcase
  end

  always_ff @(posedge clockIN) begin
    if (!nResetIN) begin
      state_q    <= StIdle;
      kind_q     <= Sync;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      gap_q      <= '0;
      last_q     <= 1'b0;
      rdy_meta_q <= 1'b1;
      rdy_sync_q <= 1'b1;
      rdy_q      <= '0;
      gnt_q      <= '0;
      data_q     <= 8'h00;
      load_q     <= 1'b0;
      err_ack_q  <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      // UART ready comes from a divided clock domain.
      rdy_meta_q <= txReadyIN;
      rdy_sync_q <= rdy_meta_q;
      load_q     <= 1'b0;
      err_ack_q  <= 1'b0;
      err_len_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|chValidIN) begin
            gnt_q   <= arb_gnt;
            ptr_q   <= arb_ptr_nxt;
            idx_q   <= arb_idx;
            cnt_q   <= '0;
            state_q <= StHdrSync;
          end
        end
        StHdrSync: begin
          data_q  <= SYNC_BYTE;
          kind_q  <= Sync;
          load_q  <= 1'b1;
          state_q <= StLoad;
        end
        StHdrId: begin
          data_q  <= {{(8 - ID_W){1'b0}}, ID_W'(idx_q)};
          kind_q  <= Id;
          load_q  <= 1'b1;
          state_q <= StLoad;
        end
        StFetch: begin
          if (take) begin
            data_q  <= ch_byte;
            last_q  <= ch_last;
            kind_q  <= Payload;
            cnt_q   <= cnt_q + CntW'(1);
            rdy_q   <= '0;
            load_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          ack_q   <= '0;
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          ack_q <= ack_q + AckW'(1);
          if (!rdy_sync_q)      state_q   <= StWaitDone;
          else if (ack_expired) err_ack_q <= 1'b1;
        end
        StWaitDone: begin
        end
        StDrain: begin
          if (take && ch_last) begin
            rdy_q   <= '0;
            gnt_q   <= '0;
            gap_q   <= '0;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (gap_q == GapW'(GAP_CLKS - 1)) state_q <= StIdle;
          else                              gap_q   <= gap_q + GapW'(1);
        end
        default: state_q <= StIdle;
      endcase

      if (byte_done) begin
        state_q <= route_st;
        if (route_st == StGap) begin
          gnt_q <= '0;
          gap_q <= '0;
        end else if (route_st inside {StFetch, StDrain}) begin
          rdy_q <= gnt_q;
        end
        if (route_st == StDrain) err_len_q <= 1'b1;
      end
    end
  end

  assign chReadyOUT = rdy_q;
  assign txDataOUT  = data_q;
  assign txLoadOUT  = load_q;
  assign grantOUT   = gnt_q;
  assign busyOUT    = (state_q != StIdle);
  assign errAckOUT  = err_ack_q;
  assign errLenOUT  = err_len_q;

endmodule

// File: tb/tb_uart_tx_sched_bins.sv
// Randomized bench for uart_tx_sched_bins against a queue-based frame/round-robin model.
module tb_uart_tx_sched_bins;

  localparam int unsigned NCH    = 8;
  localparam int unsigned MAXF   = 64;
  localparam int unsigned ACK_TO = 1023;
  localparam int unsigned GAP    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   ch_valid, ch_last, ch_ready;
  logic [8*NCH-1:0] ch_data;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             tx_load;
  logic [NCH-1:0]   grant;
  logic             busy, err_ack, err_len;

  always #5 clk = ~clk;

  uart_tx_sched_bins #(
    .NUM_CH      (NCH),
    .SYNC_BYTE   (8'hA5),
    .MAX_FRAME   (MAXF),
    .ACK_TIMEOUT (ACK_TO),
    .GAP_CLKS    (GAP)
  ) dut (
    .clockIN    (clk),
    .nResetIN   (rst_n),
    .chValidIN  (ch_valid),
    .chDataIN   (ch_data),
    .chLastIN   (ch_last),
    .chReadyOUT (ch_ready),
    .txReadyIN  (tx_ready),
    .txDataOUT  (tx_data),
    .txLoadOUT  (tx_load),
    .grantOUT   (grant),
    .busyOUT    (busy),
    .errAckOUT  (err_ack),
    .errLenOUT  (err_len)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Source side: bytes still to be offered, and the model's copy of every frame.
  logic [7:0] src_d[NCH][$];
  bit         src_l[NCH][$];
  logic [7:0] mdl_d[NCH][$];
  bit         mdl_l[NCH][$];
  bit         pend[NCH];
  bit         mid[NCH];
  bit         gaps_on, flush_req, uart_stuck;
  int         busy_left, busy_min, busy_max;
  int unsigned m_ptr;

  logic [7:0]     got_q[$];
  logic [NCH-1:0] got_g[$];
  logic [7:0]     exp_q[$];
  logic [NCH-1:0] exp_g[$];
  int             n_errack, n_errlen, gap_cyc;
  int             rdy_hi[NCH];
  longint         cyc, load_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NCH; k++)
      if (src_d[k].size() != 0 || pend[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_byte(input int ch, input logic [7:0] b, input bit last);
    src_d[ch].push_back(b);
    src_l[ch].push_back(last);
    mdl_d[ch].push_back(b);
    mdl_l[ch].push_back(last);
  endtask

  task automatic add_frame(input int ch, input int len);
    for (int i = 0; i < len; i++) push_byte(ch, 8'($urandom), i == len - 1);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_g.delete();
    n_errack = 0;
    n_errlen = 0;
    gap_cyc  = 0;
    for (int k = 0; k < NCH; k++) rdy_hi[k] = 0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_txdata"}, tx_data, 0);
    check_eq({tag, "_load"},   tx_load, 0);
    check_eq({tag, "_grant"},  grant, 0);
    check_eq({tag, "_ready"},  ch_ready, 0);
    check_eq({tag, "_busy"},   busy, 0);
    check_eq({tag, "_errs"},   {err_ack, err_len}, 0);
  endtask

  task automatic do_reset(input bit chk, input string tag);
    @(negedge clk);
    flush_req = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if (chk) check_zero(tag);
    for (int k = 0; k < NCH; k++) begin
      mdl_d[k].delete();
      mdl_l[k].delete();
    end
    m_ptr = 0;
    @(negedge clk);
  endtask

  // Expected UART stream: frames in round-robin order, header then at most MAXF payload bytes.
  task automatic run_check(input string tag, input int exp_ack, input int budget);
    int  exp_len, n, c;
    bit  found, done, l;
    logic [7:0] b;
    exp_q.delete();
    exp_g.delete();
    exp_len = 0;
    found   = 1'b1;
    while (found) begin
      found = 1'b0;
      c     = 0;
      for (int i = 0; i < NCH; i++) begin
        if (!found && mdl_d[(m_ptr + i) % NCH].size() != 0) begin
          c     = (m_ptr + i) % NCH;
          found = 1'b1;
        end
      end
      if (found) begin
        m_ptr = (c + 1) % NCH;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(c));
        exp_g.push_back(NCH'(1) << c);
        exp_g.push_back(NCH'(1) << c);
        n = 0;
        l = 1'b0;
        while (!l) begin
          b = mdl_d[c].pop_front();
          l = mdl_l[c].pop_front();
          if (n < MAXF) begin
            exp_q.push_back(b);
            exp_g.push_back(NCH'(1) << c);
          end
          n++;
        end
        if (n > MAXF) exp_len++;
      end
    end
    done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      if (all_empty() && !busy) done = 1'b1;
    end
    check_eq({tag, "_done"},   done, 1);
    check_eq({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i),  got_q[i], exp_q[i]);
      check_eq($sformatf("%s_grant%0d", tag, i), got_g[i], exp_g[i]);
    end
    check_eq({tag, "_errlen"}, n_errlen, exp_len);
    check_eq({tag, "_errack"}, n_errack, exp_ack);
  endtask

  // Monitor, UART model and source driver, all acting away from the active edge.
  initial begin
    ch_valid  = '0;
    ch_last   = '0;
    ch_data   = '0;
    tx_ready  = 1'b1;
    busy_left = 0;
    cyc       = 0;
    load_cyc  = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_load) begin
        got_q.push_back(tx_data);
        got_g.push_back(grant);
        load_cyc = cyc;
      end
      // Load clock, then ACK_TO clocks waiting for busy, then the pulse.
      if (err_ack) begin
        n_errack++;
        if (uart_stuck) check_eq("ack_delay", cyc - load_cyc, ACK_TO + 1);
      end
      if (err_len) n_errlen++;
      for (int k = 0; k < NCH; k++) if (ch_ready[k]) rdy_hi[k]++;
      if (busy && grant == '0) gap_cyc++;

      if (uart_stuck) begin
        tx_ready  = 1'b1;
        busy_left = 0;
      end else if (tx_load) begin
        busy_left = $urandom_range(busy_max, busy_min);
        tx_ready  = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_ready = 1'b1;
      end

      if (flush_req) begin
        for (int k = 0; k < NCH; k++) begin
          src_d[k].delete();
          src_l[k].delete();
          pend[k] = 1'b0;
          mid[k]  = 1'b0;
        end
        flush_req = 1'b0;
      end
      for (int k = 0; k < NCH; k++) begin
        if (pend[k]) begin
          mid[k] = !src_l[k][0];
          src_d[k].delete(0);
          src_l[k].delete(0);
        end
        if (src_d[k].size() != 0) begin
          ch_data[8*k +: 8] = src_d[k][0];
          ch_last[k]        = src_l[k][0];
          ch_valid[k]       = !(gaps_on && mid[k] && $urandom_range(3, 0) == 0);
        end else begin
          ch_valid[k] = 1'b0;
          ch_last[k]  = 1'b0;
        end
        pend[k] = ch_valid[k] && ch_ready[k] && rst_n;
      end
    end
  end

  initial begin
    int unsigned mask, nf, len;
    bit seen;
    rst_n      = 1'b0;
    gaps_on    = 1'b0;
    flush_req  = 1'b0;
    uart_stuck = 1'b0;
    busy_min   = 2;
    busy_max   = 8;
    m_ptr      = 0;
    for (int k = 0; k < NCH; k++) begin
      pend[k] = 1'b0;
      mid[k]  = 1'b0;
    end
    clear_mon();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Two-byte frame on ch2: header, payload, one ready clock per byte, GAP idle clocks.
    clear_mon();
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h22, 1'b1);
    run_check("t1", 0, 2000);
    check_eq("t1_ready2_clks", rdy_hi[2], 2);
    check_eq("t1_gap_clks", gap_cyc, GAP);
    check_eq("t1_grant_idle", grant, 0);

    // Simultaneous requests from pointer 0, then a second round.
    do_reset(1'b0, "t2");
    clear_mon();
    add_frame(0, $urandom_range(5, 1));
    add_frame(1, $urandom_range(5, 1));
    add_frame(3, $urandom_range(5, 1));
    run_check("t2a", 0, 5000);
    clear_mon();
    add_frame(0, $urandom_range(5, 1));
    add_frame(1, $urandom_range(5, 1));
    run_check("t2b", 0, 5000);

    // Oversized frame is truncated and drained; the following frame is normal.
    clear_mon();
    add_frame(1, 70);
    add_frame(3, 3);
    run_check("t3", 0, 20000);

    // UART never goes busy: every load times out, frame still completes.
    clear_mon();
    uart_stuck = 1'b1;
    add_frame(2, 1);
    run_check("t4", 3, 10000);
    uart_stuck = 1'b0;

    // Reset in the middle of the first payload byte, then a fresh pair of frames.
    clear_mon();
    busy_min = 20;
    busy_max = 20;
    add_frame(1, 4);
    seen = 1'b0;
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk);
      if (got_q.size() >= 3) seen = 1'b1;
    end
    check_eq("t5_third_load", seen, 1);
    check_eq("t5_pre_sync", got_q[0], 8'hA5);
    repeat (6) @(negedge clk);
    do_reset(1'b1, "t5_rst");
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (tx_ready) seen = 1'b1;
    end
    busy_min = 2;
    busy_max = 8;
    clear_mon();
    add_frame(3, 2);
    add_frame(0, 2);
    run_check("t5", 0, 5000);

    // Highest channel id, single byte; exactly MAXF bytes is not truncated.
    clear_mon();
    add_frame(7, 1);
    add_frame(5, MAXF);
    run_check("t6", 0, 20000);

    // Random traffic with valid gaps mid-frame.
    gaps_on = 1'b1;
    for (int r = 0; r < 5; r++) begin
      clear_mon();
      mask = $urandom_range(255, 1);
      for (int k = 0; k < NCH; k++) begin
        if (mask[k]) begin
          nf = $urandom_range(2, 1);
          for (int f = 0; f < nf; f++) begin
            len = ($urandom_range(9, 0) == 0) ? $urandom_range(67, 62) : $urandom_range(8, 1);
            add_frame(k, len);
          end
        end
      end
      run_check($sformatf("rnd%0d", r), 0, 40000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
